// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Receive side of the 6 Mbaud custom UART link. Deserialises frames of
// start bit, 8 data bits (LSB first), one even-parity bit and one stop bit,
// sampling the line on the shared 16x oversampling tick strobe. Each
// completed frame is pushed into the receive FIFO with a one-clock write
// strobe, together with its parity and framing error flags.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   undefined : one sample per bit at numTick == 7
//   defined   : majority of three samples at numTick == 6, 7, 8; every
//               decision moves to tick 8
//
// Parameters:
//   OVS           ticks per bit; only 16 is supported
//
// Ports:
//   CLK288MHZ     in   system clock, rising edge
//   resetN        in   asynchronous active-low reset
//   tick          in   16x-baud strobe, one clock wide
//   uart_rxd_out  in   serial line, asynchronous, idle high
//   fifoFull      in   receive FIFO cannot take a write this cycle
//   dataOut       out  [7:0] received byte, held until the next write
//   parityErr     out  parity bit differs from XOR of dataOut (with writeEn)
//   frameErr      out  stop bit sampled low (with writeEn)
//   writeEn       out  FIFO write strobe, one clock
//   overrun       out  one-clock pulse, frame completed while FIFO full
//   busy          out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVS = 16
) (
  input  logic       CLK288MHZ,
  input  logic       resetN,
  input  logic       tick,
  input  logic       uart_rxd_out,
  input  logic       fifoFull,
  output logic [7:0] dataOut,
  output logic       parityErr,
  output logic       frameErr,
  output logic       writeEn,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] LAST_TICK = 4'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECISION_TICK = 4'd8;
`else
  localparam logic [3:0] DECISION_TICK = 4'd7;
`endif

  // Registered state
  state_t     state;
  logic       rx_meta;
  logic       rxs;
  logic [3:0] numTick;
  logic [2:0] numBits;
  logic [7:0] shift_reg;
  logic       parity_acc;
  logic       parity_err_pend;
  logic       armed;
`ifdef UART_RX_MAJORITY_EN
  logic       samp6;
  logic       samp7;
`endif

  // Next-state values
  state_t     state_d;
  logic [3:0] numTick_d;
  logic [2:0] numBits_d;
  logic [7:0] shift_d;
  logic       parity_acc_d;
  logic       parity_err_pend_d;
  logic       armed_d;
  logic [7:0] dataOut_d;
  logic       parityErr_d;
  logic       frameErr_d;
  logic       writeEn_d;
  logic       overrun_d;
  logic       busy_d;

  logic       at_decision;
  logic       at_wrap;
  logic       sample;

  assign at_decision = tick && (numTick == DECISION_TICK);
  assign at_wrap     = tick && (numTick == LAST_TICK);

  // The bit value used at a decision: a majority of the three samples
  // around mid-bit when enabled, otherwise the live synchronised line.
`ifdef UART_RX_MAJORITY_EN
  assign sample = (samp6 & samp7) | (samp6 & rxs) | (samp7 & rxs);
`else
  assign sample = rxs;
`endif

  // State register, including the two-flop line synchroniser. The
  // synchroniser resets to the idle-high line level so that reset release
  // never looks like a start edge.
  always_ff @(posedge CLK288MHZ or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      rx_meta         <= 1'b1;
      rxs             <= 1'b1;
      numTick         <= 4'd0;
      numBits         <= 3'd0;
      shift_reg       <= 8'd0;
      parity_acc      <= 1'b0;
      parity_err_pend <= 1'b0;
      armed           <= 1'b0;
      dataOut         <= 8'd0;
      parityErr       <= 1'b0;
      frameErr        <= 1'b0;
      writeEn         <= 1'b0;
      overrun         <= 1'b0;
      busy            <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      samp6           <= 1'b1;
      samp7           <= 1'b1;
`endif
    end else begin
      state           <= state_d;
      rx_meta         <= uart_rxd_out;
      rxs             <= rx_meta;
      numTick         <= numTick_d;
      numBits         <= numBits_d;
      shift_reg       <= shift_d;
      parity_acc      <= parity_acc_d;
      parity_err_pend <= parity_err_pend_d;
      armed           <= armed_d;
      dataOut         <= dataOut_d;
      parityErr       <= parityErr_d;
      frameErr        <= frameErr_d;
      writeEn         <= writeEn_d;
      overrun         <= overrun_d;
      busy            <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      if (tick && (numTick == 4'd6)) samp6 <= rxs;
      if (tick && (numTick == 4'd7)) samp7 <= rxs;
`endif
    end
  end

  // Next-state and output logic. The frame completes at the stop-bit
  // decision rather than at the end of the stop bit, so the receiver is
  // already idle and listening when a back-to-back start edge arrives.
  always_comb begin
    state_d           = state;
    numTick_d         = numTick;
    numBits_d         = numBits;
    shift_d           = shift_reg;
    parity_acc_d      = parity_acc;
    parity_err_pend_d = parity_err_pend;
    armed_d           = armed;
    dataOut_d         = dataOut;
    parityErr_d       = parityErr;
    frameErr_d        = frameErr;
    writeEn_d         = 1'b0;
    overrun_d         = 1'b0;

    if ((state != IDLE) && tick) begin
      numTick_d = numTick + 4'd1;
    end

    case (state)
      IDLE: begin
        numTick_d = 4'd0;
        // A held-low line only yields one frame: the flag must see the
        // line high again before another start is accepted.
        if (!rxs && armed) begin
          state_d           = START;
          armed_d           = 1'b0;
          parity_acc_d      = 1'b0;
          parity_err_pend_d = 1'b0;
        end else if (rxs) begin
          armed_d = 1'b1;
        end
      end

      START: begin
        if (at_decision && sample) begin
          state_d   = IDLE;
          numTick_d = 4'd0;
        end else if (at_wrap) begin
          state_d   = DATA;
          numBits_d = 3'd0;
        end
      end

      DATA: begin
        if (at_decision) begin
          shift_d[numBits] = sample;
          parity_acc_d     = parity_acc ^ sample;
        end
        if (at_wrap) begin
          if (numBits == 3'd7) begin
            state_d = PARITY;
          end else begin
            numBits_d = numBits + 3'd1;
          end
        end
      end

      PARITY: begin
        if (at_decision) begin
          parity_err_pend_d = sample ^ parity_acc;
        end
        if (at_wrap) begin
          state_d = STOP;
        end
      end

      STOP: begin
        if (at_decision) begin
          state_d   = IDLE;
          numTick_d = 4'd0;
          if (!fifoFull) begin
            writeEn_d   = 1'b1;
            dataOut_d   = shift_reg;
            parityErr_d = parity_err_pend;
            frameErr_d  = !sample;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        numTick_d = 4'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Directed self-checking bench for uart_rx. A free-running tick strobe
// (one clock in four) paces a bit-level line driver; a monitor on the
// falling clock edge records every write strobe and overrun pulse, and
// each scenario task compares those records against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       CLK288MHZ = 1'b0;
  logic       resetN = 1'b1;
  logic       tick = 1'b0;
  logic       uart_rxd_out = 1'b1;
  logic       fifoFull = 1'b0;
  logic [7:0] dataOut;
  logic       parityErr;
  logic       frameErr;
  logic       writeEn;
  logic       overrun;
  logic       busy;

  int         checks = 0;
  int         failures = 0;

  int         wrCount = 0;
  int         ovCount = 0;
  int         bothCount = 0;
  logic [7:0] lastData = 8'h00;
  logic       lastPe = 1'b0;
  logic       lastFe = 1'b0;
  int         tickTotal = 0;
  int         lastWriteTick = 0;
  int         frameStartTick = 0;

  uart_rx #(.OVS(16)) dut (
    .CLK288MHZ   (CLK288MHZ),
    .resetN      (resetN),
    .tick        (tick),
    .uart_rxd_out(uart_rxd_out),
    .fifoFull    (fifoFull),
    .dataOut     (dataOut),
    .parityErr   (parityErr),
    .frameErr    (frameErr),
    .writeEn     (writeEn),
    .overrun     (overrun),
    .busy        (busy)
  );

  // System clock
  always #5 CLK288MHZ = ~CLK288MHZ;

  // Oversampling strobe: high for one clock out of every four
  initial begin
    forever begin
      repeat (3) @(negedge CLK288MHZ);
      tick = 1'b1;
      @(negedge CLK288MHZ);
      tick = 1'b0;
    end
  end

  // Running count of ticks seen by the DUT's clock edge
  always @(posedge CLK288MHZ) begin
    if (tick) tickTotal++;
  end

  // Capture of every write strobe and overrun pulse
  always @(negedge CLK288MHZ) begin
    if (writeEn) begin
      wrCount++;
      lastData      = dataOut;
      lastPe        = parityErr;
      lastFe        = frameErr;
      lastWriteTick = tickTotal;
    end
    if (overrun) ovCount++;
    if (writeEn && overrun) bothCount++;
  end

  task automatic waitTicks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge CLK288MHZ);
      if (tick) c++;
    end
  endtask

  task automatic sendBit(input logic b);
    @(negedge CLK288MHZ);
    uart_rxd_out = b;
    waitTicks(16);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic par, input logic stopBit);
    @(negedge CLK288MHZ);
    uart_rxd_out = 1'b0;
    frameStartTick = tickTotal;
    waitTicks(16);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    sendBit(par);
    sendBit(stopBit);
  endtask

  task automatic test_reset;
    @(negedge CLK288MHZ);
    resetN = 1'b0;
    repeat (4) @(negedge CLK288MHZ);
    checks++;
    if (dataOut !== 8'h00) begin failures++; $display("[TB] FAIL reset_dataOut: got %h expected 00", dataOut); end
    checks++;
    if (parityErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_parityErr: got %b expected 0", parityErr); end
    checks++;
    if (frameErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_frameErr: got %b expected 0", frameErr); end
    checks++;
    if (writeEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_writeEn: got %b expected 0", writeEn); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    resetN = 1'b1;
    waitTicks(32);
  endtask

  task automatic test_basic;
    int w0;
    int lat;
    w0 = wrCount;
    sendFrame(8'hA5, 1'b0, 1'b1);
    waitTicks(4);
    lat = lastWriteTick - frameStartTick;
    checks++;
    if (wrCount !== w0 + 1) begin failures++; $display("[TB] FAIL basic_writes: got %0d expected %0d", wrCount - w0, 1); end
    checks++;
    if (lastData !== 8'hA5) begin failures++; $display("[TB] FAIL basic_data: got %h expected a5", lastData); end
    checks++;
    if (lastPe !== 1'b0) begin failures++; $display("[TB] FAIL basic_parityErr: got %b expected 0", lastPe); end
    checks++;
    if (lastFe !== 1'b0) begin failures++; $display("[TB] FAIL basic_frameErr: got %b expected 0", lastFe); end
    checks++;
    if (lat < 168 || lat > 169) begin failures++; $display("[TB] FAIL basic_latency: got %0d ticks expected 168..169", lat); end
    @(negedge CLK288MHZ);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
    checks++;
    if (dataOut !== 8'hA5) begin failures++; $display("[TB] FAIL basic_data_held: got %h expected a5", dataOut); end
  endtask

  task automatic test_parity_error;
    int w0;
    w0 = wrCount;
    sendFrame(8'h01, 1'b0, 1'b1);
    waitTicks(4);
    checks++;
    if (wrCount !== w0 + 1) begin failures++; $display("[TB] FAIL parity_writes: got %0d expected %0d", wrCount - w0, 1); end
    checks++;
    if (lastData !== 8'h01) begin failures++; $display("[TB] FAIL parity_data: got %h expected 01", lastData); end
    checks++;
    if (lastPe !== 1'b1) begin failures++; $display("[TB] FAIL parity_flag: got %b expected 1", lastPe); end
    checks++;
    if (lastFe !== 1'b0) begin failures++; $display("[TB] FAIL parity_frameErr: got %b expected 0", lastFe); end
  endtask

  task automatic test_break;
    int w0;
    w0 = wrCount;
    sendFrame(8'hFF, 1'b0, 1'b0);
    waitTicks(640);
    checks++;
    if (wrCount !== w0 + 1) begin failures++; $display("[TB] FAIL break_writes: got %0d expected %0d", wrCount - w0, 1); end
    checks++;
    if (lastData !== 8'hFF) begin failures++; $display("[TB] FAIL break_data: got %h expected ff", lastData); end
    checks++;
    if (lastFe !== 1'b1) begin failures++; $display("[TB] FAIL break_frameErr: got %b expected 1", lastFe); end
    checks++;
    if (lastPe !== 1'b0) begin failures++; $display("[TB] FAIL break_parityErr: got %b expected 0", lastPe); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL break_busy_low: got %b expected 0", busy); end
    @(negedge CLK288MHZ);
    uart_rxd_out = 1'b1;
    waitTicks(32);
    checks++;
    if (wrCount !== w0 + 1) begin failures++; $display("[TB] FAIL break_release_writes: got %0d expected %0d", wrCount - w0, 1); end
  endtask

  task automatic test_glitch;
    int w0;
    w0 = wrCount;
    @(negedge CLK288MHZ);
    uart_rxd_out = 1'b0;
    waitTicks(4);
    @(negedge CLK288MHZ);
    uart_rxd_out = 1'b1;
    waitTicks(32);
    checks++;
    if (wrCount !== w0) begin failures++; $display("[TB] FAIL glitch_writes: got %0d expected 0", wrCount - w0); end
    @(negedge CLK288MHZ);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy); end
    sendFrame(8'h3C, 1'b0, 1'b1);
    waitTicks(4);
    checks++;
    if (wrCount !== w0 + 1) begin failures++; $display("[TB] FAIL glitch_next_writes: got %0d expected 1", wrCount - w0); end
    checks++;
    if (lastData !== 8'h3C) begin failures++; $display("[TB] FAIL glitch_next_data: got %h expected 3c", lastData); end
    checks++;
    if ({lastPe, lastFe} !== 2'b00) begin failures++; $display("[TB] FAIL glitch_next_flags: got %b expected 00", {lastPe, lastFe}); end
  endtask

  task automatic test_back_to_back;
    int w0;
    int o0;
    w0 = wrCount;
    o0 = ovCount;
    sendFrame(8'h12, 1'b0, 1'b1);
    fifoFull = 1'b1;
    sendFrame(8'h34, 1'b1, 1'b1);
    waitTicks(4);
    fifoFull = 1'b0;
    checks++;
    if (wrCount !== w0 + 1) begin failures++; $display("[TB] FAIL b2b_writes: got %0d expected 1", wrCount - w0); end
    checks++;
    if (lastData !== 8'h12) begin failures++; $display("[TB] FAIL b2b_first_data: got %h expected 12", lastData); end
    checks++;
    if (ovCount !== o0 + 1) begin failures++; $display("[TB] FAIL b2b_overrun: got %0d expected 1", ovCount - o0); end
    @(negedge CLK288MHZ);
    checks++;
    if (dataOut !== 8'h12) begin failures++; $display("[TB] FAIL b2b_data_held: got %h expected 12", dataOut); end
  endtask

  task automatic test_reset_mid_frame;
    int w0;
    w0 = wrCount;
    @(negedge CLK288MHZ);
    uart_rxd_out = 1'b0;
    waitTicks(16);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    @(negedge CLK288MHZ);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy); end
    resetN = 1'b0;
    uart_rxd_out = 1'b1;
    repeat (3) @(negedge CLK288MHZ);
    checks++;
    if (dataOut !== 8'h00) begin failures++; $display("[TB] FAIL midreset_dataOut: got %h expected 00", dataOut); end
    checks++;
    if ({parityErr, frameErr, writeEn, overrun, busy} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL midreset_flags: got %b expected 00000", {parityErr, frameErr, writeEn, overrun, busy});
    end
    resetN = 1'b1;
    waitTicks(48);
    checks++;
    if (wrCount !== w0) begin failures++; $display("[TB] FAIL midreset_no_write: got %0d expected 0", wrCount - w0); end
    sendFrame(8'h66, 1'b0, 1'b1);
    waitTicks(4);
    checks++;
    if (wrCount !== w0 + 1) begin failures++; $display("[TB] FAIL midreset_next_writes: got %0d expected 1", wrCount - w0); end
    checks++;
    if (lastData !== 8'h66) begin failures++; $display("[TB] FAIL midreset_next_data: got %h expected 66", lastData); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (bothCount !== 0) begin failures++; $display("[TB] FAIL write_overrun_exclusive: got %0d expected 0", bothCount); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Receive side of the 6 Mbaud custom UART link.
- Deserialises frames from the transmitter on the far end: start bit, 8 data bits LSB first, one even-parity bit (XOR of the 8 data bits), one stop bit.
- Samples the line on the shared 16x oversampling `tick` strobe.
- Pushes each completed byte plus its error flags into the receive FIFO with a single-cycle write strobe.

## Interface

Parameters:
- `OVS`, 16, ticks per bit. It sets the sample points only at 16; other values are unsupported.

Ports (one clock; reset is asynchronous and active-low):
- `CLK288MHZ` input 1: system clock. All state changes on its rising edge.
- `resetN` input 1: asynchronous active-low reset.
- `tick` input 1: 16x-baud strobe from the baud generator, one clock wide.
- `uart_rxd_out` input 1: serial line, asynchronous to `CLK288MHZ`, idle high.
- `fifoFull` input 1: receive FIFO cannot accept a write this cycle.
- `dataOut` output 8: received byte. Valid while `writeEn`=1 and held until the next write.
- `parityErr` output 1: received parity bit does not equal XOR of `dataOut`. Qualified by `writeEn`.
- `frameErr` output 1: stop bit sampled low. Qualified by `writeEn`.
- `writeEn` output 1: FIFO write strobe, one clock.
- `overrun` output 1: one-clock pulse when a frame completes while `fifoFull`=1. The frame is dropped.
- `busy` output 1: high in every state except idle.

## Operation

- **Input synchroniser:** `uart_rxd_out` passes through a 2-flop synchroniser; both flops reset to 1. Only the synchronised value `rxs` is used.
- **Counters:**
  - `numTick`, 4 bits, counts `tick` pulses 0..15 within a bit and wraps to 0 after 15.
  - `numBits`, 3 bits, indexes data bits 0..7.
- **Sample point:**
  - The decision is made on the tick where `numTick`==7, using the value of `rxs` at that tick.
  - Majority-vote variant: see Configuration.
- **Arming:**
  - An `armed` flag (reset 0) is set whenever `rxs`=1 is seen in idle.
  - A start is accepted only when `armed`=1, so a line held low (break) produces at most one frame.
- **States:**
  - idle:
    - `numTick`=0.
    - On `rxs`=0 with `armed`=1: go to start and clear `armed`.
    - Detection does not wait for `tick`.
  - start:
    - Count ticks.
    - At the decision, if the sampled value is 1 (glitch): go to idle, no write.
    - Otherwise continue counting. When `numTick` wraps 15→0, go to data with `numBits`=0.
  - data:
    - At each decision, shift the sample into the shift register at position `numBits` (LSB first) and XOR it into a running parity.
    - On wrap: if `numBits`==7, go to parity; else increment `numBits`.
  - parity:
    - At the decision, `parityErr_next` = sample XOR running parity.
    - On wrap, go to stop.
  - stop:
    - At the decision, `frameErr_next` = !sample.
    - Then complete the frame in the same cycle:
      - if `fifoFull`=0: `writeEn`=1, and `dataOut`, `parityErr`, `frameErr` are loaded;
      - if `fifoFull`=1: `overrun`=1, and the outputs keep their previous values.
    - Go to idle immediately, without waiting for the rest of the stop bit. This allows back-to-back frames.
- **Error handling:** parity and frame errors do not drop the byte. The byte is written and the flags are set.
- **Reset:**
  - Reset forces all state to idle.
  - Reset values: `dataOut`=0, `parityErr`=0, `frameErr`=0, `writeEn`=0, `overrun`=0, `busy`=0, `armed`=0.
  - Assertion mid-frame discards the partial frame; no write occurs.

## Timing

- Synchroniser latency is 2 clocks from a line edge to `rxs`.
- The start is recognised 1 clock after `rxs` falls.
- A frame spans 11 bit periods, i.e. 176 ticks, at the transmitter.
- `writeEn` rises 1 clock after the tick on which the stop bit is decided, at tick 7 of the stop bit (`numTick`==7). That is 10.5 bit periods (168 ticks) after the start edge, ± 1 tick of start-detection jitter.
- `writeEn`, `overrun` and `busy` are registered outputs.
- `writeEn` and `overrun` are never high in the same cycle.
- `tick` absent in a cycle: no counter advances.
- `fifoFull` is sampled only in the completion cycle.
- `busy` falls in the same cycle `writeEn`/`overrun` rises.

## Configuration

- `UART_RX_MAJORITY_EN`:
  - Defined: `rxs` is sampled on the ticks where `numTick`==6, 7 and 8. The bit value is the majority of the three. All decisions, including start validation and the stop-state completion, move to tick 8, so `writeEn` rises 1 tick later.
  - Undefined: a single sample at `numTick`==7, as described above.

## Test plan

- **Byte 0xA5, correct parity 0, stop 1, `fifoFull`=0** -> one `writeEn` pulse, `dataOut`=0xA5, `parityErr`=0, `frameErr`=0, `busy` low after.
- **Byte 0x01 sent with parity bit 0 (wrong)** -> `writeEn`=1, `dataOut`=0x01, `parityErr`=1.
- **Byte 0xFF with stop bit driven 0, then line held low for 40 bit times, then released** -> exactly one write with `dataOut`=0xFF and `frameErr`=1. No further frame until a new low after the line returns high.
- **Low glitch of 4 ticks on an idle line** -> no `writeEn`, return to idle. A subsequent valid 0x3C frame is received correctly.
- **Two back-to-back frames 0x12, 0x34 (no idle gap), `fifoFull`=1 during the second completion** -> write of 0x12, then `overrun` pulse, and `dataOut` stays 0x12.
- **`resetN` asserted mid-data of a 0x55 frame, released, then frame 0x66 sent** -> outputs at reset values during reset, no write for 0x55, single write of 0x66.
